pc_redirect_ctrl: RTL

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 24 ++
 rtl/pc_redirect_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg
//   Shared definitions for the fetch-PC redirect controller: FSM state
//   encodings, the default reset PC and the sequential-fetch step.
//   Ports: none (package).
package pc_redirect_ctrl_pkg;

  // Fetch controller states. RUN is the only state in which fetch may
  // consume pc_out.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_JALR = 2'd1,
    ST_FLUSH     = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam int unsigned FLUSH_CNT_W      = 4;

  // Sequential fetch address; the 32-bit add wraps naturally at 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Fetch-PC generator with decoder redirects, JALR stall and ROB flush.
//   Ports:
//     clk_in          system clock, rising edge
//     rst_in          asynchronous active-low reset
//     rdy_in          pause: all state holds while low
//     dec_valid       decoder reports the instruction at pc_out
//     dec_is_jalr     that instruction is a JALR (stall until it commits)
//     dec_redirect    JAL or predicted-taken branch
//     dec_target      predicted target for dec_redirect
//     rob_flush       mispredict detected at commit
//     rob_target      correct PC after the mispredict
//     jalr_done       a JALR committed
//     jalr_target     resolved JALR target
//     pc_out          current fetch PC (registered)
//     pc_valid        fetch may use pc_out this cycle (state RUN)
//     flush_out       registered one-cycle flush pulse to ROB/RS/LSB
//     mispredict_cnt  count of accepted rob_flush events (wraps)
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = PC_RESET_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        dec_valid,
  input  logic        dec_is_jalr,
  input  logic        dec_redirect,
  input  logic [31:0] dec_target,
  input  logic        rob_flush,
  input  logic [31:0] rob_target,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush_out,
  output logic [31:0] mispredict_cnt
);

  // Counter holds the number of FLUSH cycles remaining after the current one.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pc_state_e              state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   flush_q, flush_d;
  logic [31:0]            mis_q, mis_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    mis_d   = mis_q;
    // A commit-time mispredict overrides everything else in the cycle,
    // including a pending JALR and any decoder report.
    if (rob_flush) begin
      state_d = ST_FLUSH;
      pc_d    = rob_target;
      cnt_d   = FLUSH_RELOAD;
      flush_d = 1'b1;
      mis_d   = mis_q + 32'd1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (dec_valid) begin
            if (dec_is_jalr) begin
              state_d = ST_WAIT_JALR;
            end else if (dec_redirect) begin
              pc_d = dec_target;
            end else begin
              pc_d = next_seq_pc(pc_q);
            end
          end
        end
        ST_WAIT_JALR: begin
          if (jalr_done) begin
            pc_d    = jalr_target;
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      mis_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_valid       = (state_q == ST_RUN);
  assign flush_out      = flush_q;
  assign mispredict_cnt = mis_q;

endmodule
